mp_dcache_assoc: RTL

MP_DCACHE_ASSOC -- requirements
Module: mp_dcache_assoc

---
 rtl/mp_dcache_assoc_pkg.sv | 55 +++++
 rtl/mp_dcache_assoc_plru.sv | 56 +++++
 rtl/mp_dcache_assoc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_dcache_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_dcache_assoc_pkg
// Description : Shared definitions for the set-associative data cache:
//               controller state encoding and the tree pseudo-LRU victim and
//               update functions (supports 1, 2 and 4 ways).
// Revision    : 1.0 - initial release
// ============================================================================
package mp_dcache_assoc_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        COMPLETE  = 2'd3
    } dc_state_t;

    // Tree pseudo-LRU bits per set. bit0 is the root (0 = victim on the
    // left half, ways 0/1); bit1 picks within the left pair, bit2 within
    // the right pair. Two-way caches use bit0 only.
    localparam int c_PLRU_W = 3;

    function automatic logic [1:0] plru_victim(input logic [c_PLRU_W-1:0] bits,
                                               input int ways);
        logic [1:0] v;
        v = 2'd0;
        if (ways == 2) begin
            v = {1'b0, bits[0]};
        end else if (ways == 4) begin
            v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        end
        return v;
    endfunction

    // Point every node on the path to the accessed way away from it.
    function automatic logic [c_PLRU_W-1:0] plru_update(input logic [c_PLRU_W-1:0] bits,
                                                        input logic [1:0] way,
                                                        input int ways);
        logic [c_PLRU_W-1:0] nb;
        nb = bits;
        if (ways == 2) begin
            nb[0] = ~way[0];
        end else if (ways == 4) begin
            nb[0] = ~way[1];
            if (way[1]) begin
                nb[2] = ~way[0];
            end else begin
                nb[1] = ~way[0];
            end
        end
        return nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mp_dcache_assoc_plru.sv
`default_nettype none
// ============================================================================
// Module      : dcache_plru
// Description : Per-set pseudo-LRU state and victim selection. The victim is
//               the lowest-index invalid way of the looked-up set, otherwise
//               the way the pseudo-LRU tree points at.
// Ports       : sys_clk, sys_rst    - clock, synchronous active-high reset
//               upd_en/upd_set/upd_way - record an access (hit or refill)
//               look_set, look_valid   - set being looked up and its valid bits
//               victim                 - way to replace on a miss
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_plru
    import mp_dcache_assoc_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 32,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    input  logic [IDX_W-1:0] look_set,
    input  logic [WAYS-1:0]  look_valid,
    output logic [WAY_W-1:0] victim
);

    logic [c_PLRU_W-1:0] r_bits [SETS];
    logic                w_found;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_bits[s] <= '0;
            end
        end else if (upd_en) begin
            r_bits[upd_set] <= plru_update(r_bits[upd_set], 2'(upd_way), WAYS);
        end
    end

    always_comb begin
        victim  = WAY_W'(plru_victim(r_bits[look_set], WAYS));
        w_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!look_valid[w] && !w_found) begin
                victim  = WAY_W'(w);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mp_dcache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : mp_dcache_assoc
// Description : Blocking write-back, write-allocate set-associative data
//               cache with tree pseudo-LRU replacement. Lookup happens the
//               cycle after a request is accepted; read hits respond in that
//               cycle. Misses write back a dirty victim, refill the line and
//               finish the access in a COMPLETE cycle.
// Ports       : sys_clk/sys_rst            - clock, sync active-high reset
//               issue/stall                - request valid / not ready
//               lsu_rwn/addr/mask/data     - request (read=1, byte enables)
//               wb/wb_data                 - read response (aligned word)
//               mem_request/rwn/addr/write_data, mem_finish/read_data
//                                          - line-wide memory port
//               hit_cnt/miss_cnt           - lookup statistics
// Config      : DCACHE_STATS_EN - enable saturating hit/miss counters
//               (otherwise both outputs are tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mp_dcache_assoc
    import mp_dcache_assoc_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_BYTES = 16,
    parameter int AW         = 16
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    issue,
    output logic                    stall,
    input  logic                    lsu_rwn,
    input  logic [AW-1:0]           lsu_addr,
    input  logic [3:0]              lsu_mask,
    input  logic [31:0]             lsu_data,
    output logic                    wb,
    output logic [31:0]             wb_data,
    output logic                    mem_request,
    output logic                    mem_rwn,
    output logic [AW-1:0]           mem_addr,
    output logic [8*LINE_BYTES-1:0] mem_write_data,
    input  logic                    mem_finish,
    input  logic [8*LINE_BYTES-1:0] mem_read_data,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int c_OFF_W  = $clog2(LINE_BYTES);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_TAG_W  = AW - c_OFF_W - c_IDX_W;
    localparam int c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int c_WSEL_W = (c_OFF_W > 2) ? c_OFF_W - 2 : 1;
    localparam int c_LINE_W = 8 * LINE_BYTES;

    // Captured request
    logic                r_lookup;
    logic                r_req_rwn;
    logic [3:0]          r_req_mask;
    logic [31:0]         r_req_data;
    logic [c_TAG_W-1:0]  r_req_tag;
    logic [c_IDX_W-1:0]  r_req_set;
    logic [c_WSEL_W-1:0] r_req_word;

    // Controller
    dc_state_t           r_state;
    logic [c_WAY_W-1:0]  r_way;

    // Tag/state arrays and line storage
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [c_TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [c_LINE_W-1:0] r_line  [SETS][WAYS];

    logic                w_accept;
    logic                w_hit;
    logic [c_WAY_W-1:0]  w_hit_way;
    logic                w_lookup_hit;
    logic                w_lookup_miss;
    logic [c_WAY_W-1:0]  w_victim;
    logic                w_refill_done;
    logic [c_WAY_W-1:0]  w_rd_way;
    logic [c_LINE_W-1:0] w_rd_line;
    logic [c_LINE_W-1:0] w_merged;
    logic                w_line_we;
    logic [c_WAY_W-1:0]  w_line_way;
    logic [c_LINE_W-1:0] w_line_val;
    logic                w_plru_upd;
    logic [c_WAY_W-1:0]  w_plru_way;
    logic [c_WSEL_W-1:0] w_req_word;
    logic                w_unused_addr_lsbs;

    // Sub-word address bits select bytes inside the word; the consumer
    // extracts them from the aligned word, so the cache ignores them.
    assign w_unused_addr_lsbs = ^lsu_addr[1:0];

    generate
        if (c_OFF_W > 2) begin : g_word_sel
            assign w_req_word = lsu_addr[c_OFF_W-1:2];
        end else begin : g_word_single
            assign w_req_word = '0;
        end
    endgenerate

    function automatic logic [c_LINE_W-1:0] merge_word(input logic [c_LINE_W-1:0] line,
                                                       input logic [c_WSEL_W-1:0] word,
                                                       input logic [3:0]          mask,
                                                       input logic [31:0]         data);
        logic [c_LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[int'(word)*32 + b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Lookup: parallel tag compare against the captured request
    // ------------------------------------------------------------------
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[r_req_set][w] && (r_tag[r_req_set][w] == r_req_tag) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    assign w_lookup_hit  = r_lookup & w_hit;
    assign w_lookup_miss = r_lookup & ~w_hit;
    assign w_refill_done = (r_state == REFILL) & mem_finish;

    // COMPLETE releases stall so the next request can be accepted while the
    // pending access is finished against the refilled line.
    assign stall    = w_lookup_miss | (r_state == WRITEBACK) | (r_state == REFILL);
    assign w_accept = issue & ~stall;

    // One read path serves both the hit response and the COMPLETE response;
    // it also feeds the byte merge for writes.
    assign w_rd_way  = (r_state == COMPLETE) ? r_way : w_hit_way;
    assign w_rd_line = r_line[r_req_set][w_rd_way];
    assign w_merged  = merge_word(w_rd_line, r_req_word, r_req_mask, r_req_data);
    assign wb        = r_req_rwn & (w_lookup_hit | (r_state == COMPLETE));
    assign wb_data   = w_rd_line[int'(r_req_word)*32 +: 32];

    assign mem_write_data = r_line[r_req_set][r_way];

    // Single line write port: refill data, or a merged word on write
    // hit / write completion. These never coincide.
    always_comb begin
        w_line_we  = 1'b0;
        w_line_way = r_way;
        w_line_val = w_merged;
        if (w_refill_done) begin
            w_line_we  = 1'b1;
            w_line_val = mem_read_data;
        end else if ((r_state == COMPLETE) && !r_req_rwn) begin
            w_line_we  = 1'b1;
        end else if (w_lookup_hit && !r_req_rwn) begin
            w_line_we  = 1'b1;
            w_line_way = w_hit_way;
        end
    end

    assign w_plru_upd = w_lookup_hit | w_refill_done;
    assign w_plru_way = w_lookup_hit ? w_hit_way : r_way;

    dcache_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .upd_en     (w_plru_upd),
        .upd_set    (r_req_set),
        .upd_way    (w_plru_way),
        .look_set   (r_req_set),
        .look_valid (r_valid[r_req_set]),
        .victim     (w_victim)
    );

    // ------------------------------------------------------------------
    // Request capture and line storage (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_req_rwn  <= lsu_rwn;
            r_req_mask <= lsu_mask;
            r_req_data <= lsu_data;
            r_req_tag  <= lsu_addr[AW-1 -: c_TAG_W];
            r_req_set  <= lsu_addr[c_OFF_W +: c_IDX_W];
            r_req_word <= w_req_word;
        end
        if (w_line_we) begin
            r_line[r_req_set][w_line_way] <= w_line_val;
        end
    end

    // ------------------------------------------------------------------
    // Controller with registered memory-port outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= READY;
            r_lookup    <= 1'b0;
            r_way       <= '0;
            mem_request <= 1'b0;
            mem_rwn     <= 1'b1;
            mem_addr    <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            r_lookup <= w_accept;
            case (r_state)
                READY: begin
                    if (w_lookup_hit) begin
                        if (!r_req_rwn) begin
                            r_dirty[r_req_set][w_hit_way] <= 1'b1;
                        end
                    end else if (w_lookup_miss) begin
                        r_way       <= w_victim;
                        mem_request <= 1'b1;
                        if (r_valid[r_req_set][w_victim] && r_dirty[r_req_set][w_victim]) begin
                            r_state  <= WRITEBACK;
                            mem_rwn  <= 1'b0;
                            mem_addr <= {r_tag[r_req_set][w_victim], r_req_set, {c_OFF_W{1'b0}}};
                        end else begin
                            r_state  <= REFILL;
                            mem_rwn  <= 1'b1;
                            mem_addr <= {r_req_tag, r_req_set, {c_OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays high: the refill read follows directly.
                    if (mem_finish) begin
                        r_state  <= REFILL;
                        mem_rwn  <= 1'b1;
                        mem_addr <= {r_req_tag, r_req_set, {c_OFF_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (mem_finish) begin
                        r_state                      <= COMPLETE;
                        mem_request                  <= 1'b0;
                        r_valid[r_req_set][r_way]    <= 1'b1;
                        r_dirty[r_req_set][r_way]    <= 1'b0;
                        r_tag[r_req_set][r_way]      <= r_req_tag;
                    end
                end
                COMPLETE: begin
                    r_state <= READY;
                    if (!r_req_rwn) begin
                        r_dirty[r_req_set][r_way] <= 1'b1;
                    end
                end
                default: r_state <= READY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire
